reg_unshift: RTL and testbench

//   Parallel-to-serial converter: the read-out end of the tap delay line.

---
 rtl/reg_unshift_if.sv | 24 ++
 rtl/reg_unshift.sv | 78 +++++++
 tb/tb_reg_unshift.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_unshift_if.sv
// Load/serial-stream bundle for reg_unshift: parallel vector in, one word per handshake out.
interface reg_unshift_if #(
   parameter int unsigned N = 8,
   parameter int unsigned W = 1
);
   logic [W*N-1:0] din_all;
   logic           load_valid;
   logic           load_ready;
   logic [W-1:0]   dout;
   logic           dout_valid;
   logic           dout_ready;
   logic           dout_last;
   logic           busy;

   modport master (
      output din_all, load_valid, dout_ready,
      input  load_ready, dout, dout_valid, dout_last, busy
   );

   modport slave (
      input  din_all, load_valid, dout_ready,
      output load_ready, dout, dout_valid, dout_last, busy
   );
endinterface

// File: rtl/reg_unshift.sv
// Parallel-to-serial converter: takes an N-word vector per load and streams its words out
// on a valid/ready handshake, MSW first (DIR=0) or LSW first (DIR=1).
module reg_unshift #(
   parameter int unsigned N   = 8,
   parameter int unsigned W   = 1,
   parameter int unsigned DIR = 0
) (
   input logic         clk,
   input logic         rst_n,
   reg_unshift_if.slave bus
);
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LastCnt = CW'(N - 1);

   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StShift = 1'b1;

   logic [0:0]     state_q, state_d;
   logic [W*N-1:0] sh_q, sh_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W*N-1:0] sh_next;
   logic           out_valid, out_last, word_acc, load_acc;

   // Register contents after the current head word has been consumed.
   if (N == 1) begin : g_noshift
      assign sh_next = sh_q;
   end else if (DIR == 0) begin : g_msw
      assign sh_next = {sh_q[0 +: W*(N-1)], {W{1'b0}}};
   end else begin : g_lsw
      assign sh_next = {{W{1'b0}}, sh_q[W*N-1 -: W*(N-1)]};
   end

   if (DIR == 0) begin : g_out_msw
      assign bus.dout = sh_q[W*N-1 -: W];
   end else begin : g_out_lsw
      assign bus.dout = sh_q[0 +: W];
   end

   assign out_valid      = (state_q == StShift);
   assign out_last       = out_valid & (cnt_q == LastCnt);
   assign word_acc       = out_valid & bus.dout_ready;
   assign bus.load_ready = (state_q == StIdle) | (word_acc & out_last);
   assign load_acc       = bus.load_valid & bus.load_ready;
   assign bus.dout_valid = out_valid;
   assign bus.dout_last  = out_last;
   assign bus.busy       = out_valid;

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      if (load_acc) begin
         // Covers both the idle load and the back-to-back load on the last-word accept.
         state_d = StShift;
         sh_d    = bus.din_all;
         cnt_d   = '0;
      end else if (word_acc) begin
         sh_d = sh_next;
         if (out_last) begin
            state_d = StIdle;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         sh_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_reg_unshift.sv
// Directed bench for reg_unshift: MSW/LSW order, backpressure, back-to-back, reset, N=1.
module tb_reg_unshift;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   reg_unshift_if #(.N(4), .W(8))  ia ();
   reg_unshift_if #(.N(4), .W(8))  ib ();
   reg_unshift_if #(.N(1), .W(16)) ic ();

   reg_unshift #(.N(4), .W(8), .DIR(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
   reg_unshift #(.N(4), .W(8), .DIR(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
   reg_unshift #(.N(1), .W(16), .DIR(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      ia.load_valid = 0; ia.dout_ready = 0; ia.din_all = '0;
      ib.load_valid = 0; ib.dout_ready = 0; ib.din_all = '0;
      ic.load_valid = 0; ic.dout_ready = 0; ic.din_all = '0;
      rst_n = 0;
      step();
      step();
      rst_n = 1;
      total++;
      if (ia.dout_valid !== 1'b0 || ia.dout !== 8'h00 || ia.dout_last !== 1'b0 ||
          ia.busy !== 1'b0 || ia.load_ready !== 1'b1)
         $display("FAIL reset_a: v=%b d=%h l=%b b=%b lr=%b want 0 00 0 0 1",
                  ia.dout_valid, ia.dout, ia.dout_last, ia.busy, ia.load_ready);
      else passed++;
      total++;
      if (ib.dout_valid !== 1'b0 || ib.dout !== 8'h00 || ic.dout_valid !== 1'b0 ||
          ic.dout !== 16'h0000 || ic.load_ready !== 1'b1)
         $display("FAIL reset_bc: bv=%b bd=%h cv=%b cd=%h clr=%b want 0 00 0 0000 1",
                  ib.dout_valid, ib.dout, ic.dout_valid, ic.dout, ic.load_ready);
      else passed++;
   endtask

   task automatic test_msw_first();
      logic [7:0] exp [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
      ia.din_all = 32'h44332211; ia.load_valid = 1; ia.dout_ready = 1;
      step();
      ia.load_valid = 0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (ia.dout_valid !== 1'b1 || ia.dout !== exp[i] || ia.dout_last !== (i == 3) ||
             ia.busy !== 1'b1)
            $display("FAIL msw_word%0d: v=%b d=%h l=%b b=%b want 1 %h %b 1", i,
                     ia.dout_valid, ia.dout, ia.dout_last, ia.busy, exp[i], (i == 3));
         else passed++;
         step();
      end
      total++;
      if (ia.dout_valid !== 1'b0 || ia.load_ready !== 1'b1)
         $display("FAIL msw_end: v=%b lr=%b want 0 1", ia.dout_valid, ia.load_ready);
      else passed++;
   endtask

   task automatic test_lsw_first();
      logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      ib.din_all = 32'h44332211; ib.load_valid = 1; ib.dout_ready = 1;
      step();
      ib.load_valid = 0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (ib.dout_valid !== 1'b1 || ib.dout !== exp[i] || ib.dout_last !== (i == 3))
            $display("FAIL lsw_word%0d: v=%b d=%h l=%b want 1 %h %b", i,
                     ib.dout_valid, ib.dout, ib.dout_last, exp[i], (i == 3));
         else passed++;
         step();
      end
      total++;
      if (ib.dout_valid !== 1'b0)
         $display("FAIL lsw_end: v=%b want 0", ib.dout_valid);
      else passed++;
   endtask

   task automatic test_backpressure();
      logic [7:0] exp [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
      logic       pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      int         idx = 0;
      ia.din_all = 32'h44332211; ia.load_valid = 1; ia.dout_ready = 0;
      step();
      ia.load_valid = 0;
      for (int k = 0; k < 7; k++) begin
         ia.dout_ready = pat[k];
         #1;
         total++;
         if (ia.dout_valid !== 1'b1 || ia.dout !== exp[idx] || ia.dout_last !== (idx == 3) ||
             ia.load_ready !== (pat[k] && idx == 3))
            $display("FAIL bp_cycle%0d: v=%b d=%h l=%b lr=%b want 1 %h %b %b", k,
                     ia.dout_valid, ia.dout, ia.dout_last, ia.load_ready, exp[idx],
                     (idx == 3), (pat[k] && idx == 3));
         else passed++;
         if (pat[k]) idx++;
         step();
      end
      total++;
      if (ia.dout_valid !== 1'b0 || idx != 4)
         $display("FAIL bp_end: v=%b words=%0d want 0 4", ia.dout_valid, idx);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp [8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
      ia.din_all = 32'h44332211; ia.load_valid = 1; ia.dout_ready = 1;
      step();
      ia.din_all = 32'hDDCCBBAA;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (ia.dout_valid !== 1'b1 || ia.dout !== exp[i] ||
             ia.dout_last !== (i == 3 || i == 7) || ia.load_ready !== (i == 3 || i == 7))
            $display("FAIL b2b_word%0d: v=%b d=%h l=%b lr=%b want 1 %h %b %b", i,
                     ia.dout_valid, ia.dout, ia.dout_last, ia.load_ready, exp[i],
                     (i == 3 || i == 7), (i == 3 || i == 7));
         else passed++;
         step();
         if (i == 3) ia.load_valid = 0;
      end
      total++;
      if (ia.dout_valid !== 1'b0)
         $display("FAIL b2b_end: v=%b want 0", ia.dout_valid);
      else passed++;
   endtask

   task automatic test_reset_mid_burst();
      logic [7:0] exp [4] = '{8'h00, 8'h00, 8'h00, 8'hFF};
      ia.din_all = 32'h44332211; ia.load_valid = 1; ia.dout_ready = 1;
      step();
      ia.load_valid = 0;
      step();
      step();
      total++;
      if (ia.dout !== 8'h22 || ia.dout_valid !== 1'b1)
         $display("FAIL rst_pre: d=%h v=%b want 22 1", ia.dout, ia.dout_valid);
      else passed++;
      rst_n = 0;
      step();
      rst_n = 1;
      total++;
      if (ia.dout_valid !== 1'b0 || ia.dout !== 8'h00 || ia.load_ready !== 1'b1 ||
          ia.dout_last !== 1'b0)
         $display("FAIL rst_mid: v=%b d=%h lr=%b l=%b want 0 00 1 0",
                  ia.dout_valid, ia.dout, ia.load_ready, ia.dout_last);
      else passed++;
      step();
      total++;
      if (ia.dout_valid !== 1'b0)
         $display("FAIL rst_idle: v=%b want 0", ia.dout_valid);
      else passed++;
      ia.din_all = 32'h000000FF; ia.load_valid = 1;
      step();
      ia.load_valid = 0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (ia.dout_valid !== 1'b1 || ia.dout !== exp[i] || ia.dout_last !== (i == 3))
            $display("FAIL rst_reload%0d: v=%b d=%h l=%b want 1 %h %b", i,
                     ia.dout_valid, ia.dout, ia.dout_last, exp[i], (i == 3));
         else passed++;
         step();
      end
   endtask

   task automatic test_single_word();
      logic [15:0] exp [2] = '{16'hBEEF, 16'h1234};
      ic.din_all = 16'hBEEF; ic.load_valid = 1; ic.dout_ready = 1;
      step();
      ic.din_all = 16'h1234;
      for (int i = 0; i < 2; i++) begin
         total++;
         if (ic.dout_valid !== 1'b1 || ic.dout !== exp[i] || ic.dout_last !== 1'b1 ||
             ic.load_ready !== 1'b1)
            $display("FAIL n1_word%0d: v=%b d=%h l=%b lr=%b want 1 %h 1 1", i,
                     ic.dout_valid, ic.dout, ic.dout_last, ic.load_ready, exp[i]);
         else passed++;
         step();
         ic.load_valid = 0;
      end
      total++;
      if (ic.dout_valid !== 1'b0 || ic.load_ready !== 1'b1)
         $display("FAIL n1_end: v=%b lr=%b want 0 1", ic.dout_valid, ic.load_ready);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_msw_first();
      test_lsw_first();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_burst();
      test_single_word();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
